// File: rtl/gray_rx_checker_if.sv
// rtl/gray_rx_checker_if.sv - Gray count bus and decoded/status bundle for gray_rx_checker
interface gray_rx_checker_if #(
    parameter int CBITS  = 8,
    parameter int ECBITS = 4
);
    logic [CBITS-1:0]  gray_in;
    logic              in_valid;
    logic              clr_err;
    logic [CBITS-1:0]  bin_out;
    logic              bin_valid;
    logic              locked;
    logic              err;
    logic              wrap;
    logic [ECBITS-1:0] err_cnt;

    modport master (
        output gray_in, in_valid, clr_err,
        input  bin_out, bin_valid, locked, err, wrap, err_cnt
    );

    modport slave (
        input  gray_in, in_valid, clr_err,
        output bin_out, bin_valid, locked, err, wrap, err_cnt
    );
endinterface

// File: rtl/gray_rx_checker.sv
// rtl/gray_rx_checker.sv - Gray count decoder with +1 sequence lock tracking and error counting
module gray_rx_checker #(
    parameter int CBITS  = 8,
    parameter int LOCK_N = 2,
    parameter int ECBITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    gray_rx_checker_if.slave   bus
);
    typedef enum logic {ACQ, LOCK} state_t;

    state_t            state, nstate;
    logic [CBITS-1:0]  d;
    logic [CBITS-1:0]  prev, nprev;
    logic              have_prev, nhave;
    logic [3:0]        good_run, ngood;
    logic              nerr, nwrap;

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < CBITS; i++) begin : g_dec
        assign d[i] = ^bus.gray_in[CBITS-1:i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ACQ;
            prev          <= '0;
            have_prev     <= 1'b0;
            good_run      <= '0;
            bus.bin_out   <= '0;
            bus.bin_valid <= 1'b0;
            bus.err       <= 1'b0;
            bus.wrap      <= 1'b0;
            bus.err_cnt   <= '0;
        end else begin
            state         <= nstate;
            prev          <= nprev;
            have_prev     <= nhave;
            good_run      <= ngood;
            bus.bin_valid <= bus.in_valid;
            bus.err       <= nerr;
            bus.wrap      <= nwrap;
            if (bus.in_valid) begin
                bus.bin_out <= d;
            end
            // Clear takes priority over a same-edge increment.
            if (bus.clr_err) begin
                bus.err_cnt <= '0;
            end else if (nerr && (bus.err_cnt != {ECBITS{1'b1}})) begin
                bus.err_cnt <= bus.err_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nstate = state;
        nprev  = prev;
        nhave  = have_prev;
        ngood  = good_run;
        nerr   = 1'b0;
        nwrap  = 1'b0;
        if (bus.in_valid) begin
            if (!have_prev) begin
                nprev = d;
                nhave = 1'b1;
                ngood = '0;
            end else if (d == prev + 1'b1) begin
                nprev = d;
                if (state == ACQ) begin
                    if (good_run + 4'd1 == 4'(LOCK_N)) begin
                        nstate = LOCK;
                        ngood  = '0;
                    end else begin
                        ngood = good_run + 4'd1;
                    end
                end else begin
                    nwrap = (d == '0);
                end
            end else if (d != prev) begin
                // Sequence break; only reported as an error when it costs us lock.
                nprev  = d;
                nerr   = (state == LOCK);
                nstate = ACQ;
                ngood  = '0;
            end
        end
    end

    assign bus.locked = (state == LOCK);
endmodule

// File: tb/tb_gray_rx_checker.sv
// tb/tb_gray_rx_checker.sv - Directed self-checking bench for gray_rx_checker
module tb_gray_rx_checker;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] b;
    int   exp_cnt;

    gray_rx_checker_if #(.CBITS(8), .ECBITS(4)) bus ();

    gray_rx_checker #(.CBITS(8), .LOCK_N(2), .ECBITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] enc(input logic [7:0] v);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [7:0] g);
        bus.gray_in  = g;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.gray_in = '0;
        bus.in_valid = 1'b0;
        bus.clr_err = 1'b0;
        @(negedge clk);
        chk("rst_bin_out", 32'(bus.bin_out), 0);
        chk("rst_bin_valid", 32'(bus.bin_valid), 0);
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Acquire lock on 0..3
        step(8'h00);
        chk("t1_bin0", 32'(bus.bin_out), 0);
        chk("t1_valid0", 32'(bus.bin_valid), 1);
        chk("t1_lock0", 32'(bus.locked), 0);
        step(8'h01);
        chk("t1_bin1", 32'(bus.bin_out), 1);
        chk("t1_lock1", 32'(bus.locked), 0);
        step(8'h03);
        chk("t1_bin2", 32'(bus.bin_out), 2);
        chk("t1_lock2", 32'(bus.locked), 1);
        step(8'h02);
        chk("t1_bin3", 32'(bus.bin_out), 3);
        chk("t1_err3", 32'(bus.err), 0);
        idle();
        chk("t1_valid_idle", 32'(bus.bin_valid), 0);

        // Run up to 253 and through the wrap
        for (int i = 4; i <= 253; i++) step(enc(8'(i)));
        chk("t2_bin253", 32'(bus.bin_out), 253);
        chk("t2_lock253", 32'(bus.locked), 1);
        step(8'h81);
        chk("t2_bin254", 32'(bus.bin_out), 254);
        chk("t2_wrap254", 32'(bus.wrap), 0);
        step(8'h80);
        chk("t2_wrap255", 32'(bus.wrap), 0);
        step(8'h00);
        chk("t2_bin0", 32'(bus.bin_out), 0);
        chk("t2_wrap0", 32'(bus.wrap), 1);
        chk("t2_lock0", 32'(bus.locked), 1);
        chk("t2_err0", 32'(bus.err), 0);
        step(8'h01);
        chk("t2_wrap_after", 32'(bus.wrap), 0);

        // Break at 5 -> 8, then re-lock on 9, 10
        step(8'h03); step(8'h02); step(8'h06); step(8'h07);
        chk("t3_lock5", 32'(bus.locked), 1);
        step(8'h0C);
        chk("t3_bin8", 32'(bus.bin_out), 8);
        chk("t3_err", 32'(bus.err), 1);
        chk("t3_unlock", 32'(bus.locked), 0);
        chk("t3_cnt", 32'(bus.err_cnt), 1);
        step(8'h0D);
        chk("t3_err_gone", 32'(bus.err), 0);
        chk("t3_lock9", 32'(bus.locked), 0);
        step(8'h0F);
        chk("t3_relock", 32'(bus.locked), 1);

        // Repeats and gaps while locked at 10
        for (int i = 0; i < 3; i++) begin
            step(8'h0F);
            chk("t4_hold_err", 32'(bus.err), 0);
            chk("t4_hold_lock", 32'(bus.locked), 1);
            chk("t4_hold_valid", 32'(bus.bin_valid), 1);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t4_gap_valid", 32'(bus.bin_valid), 0);
            chk("t4_gap_bin", 32'(bus.bin_out), 10);
            chk("t4_gap_lock", 32'(bus.locked), 1);
        end
        step(8'h0E);
        chk("t4_bin11", 32'(bus.bin_out), 11);
        chk("t4_lock11", 32'(bus.locked), 1);

        // 20 breaks with re-lock between; counter saturates
        b = 8'd11;
        exp_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            b = b + 8'd5;
            step(enc(b));
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            chk("t5_err", 32'(bus.err), 1);
            chk("t5_cnt", 32'(bus.err_cnt), 32'(exp_cnt));
            b = b + 8'd1; step(enc(b));
            b = b + 8'd1; step(enc(b));
        end
        chk("t5_sat", 32'(bus.err_cnt), 15);
        chk("t5_locked", 32'(bus.locked), 1);
        b = b + 8'd5;
        bus.clr_err = 1'b1;
        step(enc(b));
        bus.clr_err = 1'b0;
        chk("t5_clr_err", 32'(bus.err), 1);
        chk("t5_clr_cnt", 32'(bus.err_cnt), 0);
        chk("t5_clr_unlock", 32'(bus.locked), 0);
        b = b + 8'd1; step(enc(b));
        b = b + 8'd1; step(enc(b));
        b = b + 8'd9; step(enc(b));
        chk("t6_pre_cnt", 32'(bus.err_cnt), 1);
        b = b + 8'd1; step(enc(b));
        b = b + 8'd1; step(enc(b));
        chk("t6_pre_lock", 32'(bus.locked), 1);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_lock", 32'(bus.locked), 0);
        chk("t6_async_bin", 32'(bus.bin_out), 0);
        chk("t6_async_cnt", 32'(bus.err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        step(enc(8'd100));
        chk("t6_first_err", 32'(bus.err), 0);
        chk("t6_first_lock", 32'(bus.locked), 0);
        chk("t6_first_bin", 32'(bus.bin_out), 100);
        step(enc(8'd50));
        chk("t6_acq_bad_err", 32'(bus.err), 0);
        chk("t6_acq_bad_cnt", 32'(bus.err_cnt), 0);
        step(enc(8'd51));
        chk("t6_run1_lock", 32'(bus.locked), 0);
        step(enc(8'd52));
        chk("t6_relock", 32'(bus.locked), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_rx_checker.md
Name: gray_rx_checker

Overview:
Receive side of the Gray-coded counter interface. Samples a Gray-coded count bus and decodes it to binary. Tracks lock on the expected +1 sequence and flags sequence breaks. Sits downstream of a Gray counter, across a timing or clock-domain boundary, as a monitor and decoder.

Parameters:
CBITS, 8, width of the Gray and binary count (≥ 2)
LOCK_N, 2, number of consecutive good +1 steps needed to enter LOCK (1..15)
ECBITS, 4, width of the saturating error counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  reset, asynchronous, active-high
gray_in  input  CBITS  Gray-coded count
in_valid  input  1  gray_in is sampled this cycle
clr_err  input  1  synchronous clear of err_cnt
bin_out  output  CBITS  registered decoded binary value
bin_valid  output  1  bin_out updated this cycle (1-cycle pulse)
locked  output  1  high while FSM is in LOCK
err  output  1  1-cycle pulse on a sequence break while locked
wrap  output  1  1-cycle pulse on a locked good step to 0
err_cnt  output  ECBITS  saturating count of err pulses

Behaviour:
- Reset (async, rst=1): bin_out=0, bin_valid=0, locked=0, err=0, wrap=0, err_cnt=0. Internal state: prev=0, have_prev=0, good_run=0, FSM=ACQ. Asserting rst mid-sequence discards lock immediately; outputs return to reset values without waiting for a clock.
- Decode (combinational on gray_in): b[CBITS-1]=g[CBITS-1]; b[i]=b[i+1]^g[i] for i=CBITS-2..0. Call the result d.
- Latency: on an edge with in_valid=1, bin_out<=d and bin_valid<=1, so values appear one cycle after sampling. On edges with in_valid=0, bin_valid<=0, bin_out holds, and all other state holds.
- Step classification on a sampled edge with have_prev=1, using modulo-2^CBITS arithmetic:
  - GOOD: d == prev+1. This includes the wrap from all-ones to 0.
  - HOLD: d == prev. Treated as a stall: no state change except bin_out/bin_valid.
  - BAD: anything else.
- First sample after reset (have_prev=0): prev<=d, have_prev<=1, good_run=0, no classification.
- On GOOD and BAD, prev<=d.
- FSM ACQ:
  - GOOD: good_run++. When good_run reaches LOCK_N, go to LOCK and clear good_run.
  - BAD: good_run<=0. No err pulse.
- FSM LOCK:
  - GOOD: stay in LOCK. If d==0, pulse wrap.
  - BAD: pulse err, go to ACQ, good_run<=0.
  - HOLD: stay in LOCK.
- Output timing: locked is registered and equals (FSM==LOCK). err and wrap are registered pulses, asserted the cycle after the offending or wrapping sample, the same cycle as the matching bin_valid.
- err_cnt:
  - Increments on each err pulse and saturates at 2^ECBITS-1.
  - clr_err=1 sets it to 0, and clear wins over a simultaneous increment.
  - clr_err does not affect the FSM.
- Simultaneous events: a single sample cannot be both GOOD and BAD. A wrap sample in ACQ gives no wrap pulse, even if that same step causes entry to LOCK.
- Invariants for formal checks:
  - err implies that locked was high in the previous cycle.
  - wrap implies bin_out==0.
  - err and wrap are never high together.
  - Once locked, locked stays high as long as only GOOD/HOLD samples arrive and rst stays low.

Test Plan:
1. Reset then in_valid=1 with gray 0x00,0x01,0x03,0x02 (bin 0..3) → bin_out 0,1,2,3 each one cycle later. locked rises after sample bin 2 (visible with bin_out=2). No err.
2. Locked at bin 253, then gray 0x81,0x80,0x00 (bin 254,255,0) → wrap pulses exactly once, in the cycle bin_out=0. locked stays 1 and err stays 0.
3. Locked at bin 5 (gray 0x07), then gray 0x0C (bin 8) → err=1 for one cycle, locked=0 the same cycle, err_cnt=1. Two further good steps (bin 9,10) re-lock.
4. Locked, gray repeated (0x03 three times), and in_valid deasserted for 4 cycles → no err. locked held. bin_valid pulses only on valid cycles.
5. ECBITS=4: force 20 breaks, each re-locked in between → err_cnt saturates at 15. Then clr_err=1 in the same cycle as an err pulse → err_cnt=0.
6. Locked mid-stream, assert rst asynchronously between edges → locked, bin_out and err_cnt go to 0 immediately. The first sample after release gives no err and no lock.
